mem_resp: RTL and testbench
===========================

Name: mem_resp

Overview:
- Memory-side responder for the core's memory initiators.
- Serves two requester ports: instruction fetch (I port, driven by the fetch-address stage) and data access (D port, driven by the memory-access stage).
- Owns the word-addressed storage array and arbitrates at most one access per cycle between the ports.
- Returns read data after a fixed latency.

Parameters:
- DATA_W, default `SIZE_DATA, data word width
- ADDR_W, default `SIZE_ADDR, request address width
- DEPTH_LOG2, default 10, log2 of storage words; array index = addr[DEPTH_LOG2-1:0], upper address bits ignored (aliasing)
- LAT, default 2, read latency in cycles from acceptance to response; legal range 1..4

Ports:
- iw_clk  in  1  clock
- iw_rst  in  1  synchronous active-high reset
- iw_i_valid  in  1  I-port read request valid
- ow_i_ready  out  1  I-port request accepted this cycle
- iw_i_addr  in  ADDR_W  I-port read address
- ow_i_rsp_valid  out  1  I-port read data valid (single-cycle pulse)
- ow_i_rsp_data  out  DATA_W  I-port read data
- iw_d_valid  in  1  D-port request valid
- ow_d_ready  out  1  D-port request accepted this cycle
- iw_d_we  in  1  D-port write enable (1 = write, 0 = read)
- iw_d_addr  in  ADDR_W  D-port address
- iw_d_wdata  in  DATA_W  D-port write data
- ow_d_rsp_valid  out  1  D-port read data valid (single-cycle pulse)
- ow_d_rsp_data  out  DATA_W  D-port read data

Behaviour:
- Clock and reset: one clock, iw_clk; reset iw_rst is synchronous and active-high.
- Reset values:
  - ow_*_rsp_valid = 0; ow_*_rsp_data = 0.
  - Latency pipeline cleared.
  - Round-robin pointer set to "D granted last", so the I port wins the first conflict.
  - Storage array contents are not reset.
- Reset mid-operation: all in-flight reads are dropped; no response is emitted for them.
- Handshake:
  - A request transfers when valid && ready in the same cycle.
  - ready is combinational from the valids and the round-robin pointer.
  - ready is meaningful only when valid = 1; it is driven 0 while iw_rst = 1.
- Arbitration:
  - Only I valid: I granted.
  - Only D valid: D granted.
  - Both valid: grant the port not granted at the last conflict.
  - The pointer updates only on conflict cycles.
  - The requester holds valid, addr and data stable until ready.
- Reads:
  - The array word is captured in the acceptance cycle and travels down a LAT-deep pipeline tagged with its port id.
  - Exactly LAT cycles later, the matching ow_x_rsp_valid pulses for 1 cycle with the data.
  - Responses have no backpressure.
  - At most one response fires per cycle across both ports.
  - Responses are in order per port.
- Writes (D port, iw_d_we = 1):
  - The array is updated at the clock edge ending the acceptance cycle.
  - No response is generated.
- Ordering:
  - A read accepted in the cycle after a write to the same index returns the new data.
  - A write accepted while an earlier read to the same index is still in flight does not alter that read's response, because data is captured at acceptance.
- Throughput: 1 accepted request per cycle sustained; no bubbles.
- Between responses, ow_*_rsp_data holds its last value.

Optional Feature:
- Macro: MEM_RESP_STATS_EN.
- Defined:
  - Adds outputs ow_conflict_cnt [15:0] (cycles with both valids high) and ow_stall_cnt [15:0] (cycles with any valid && !ready).
  - Both counters reset to 0 and saturate at 16'hFFFF.
- Undefined: the ports and counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared include src2/mem.vh holds:
  - default DEPTH_LOG2 and LAT values;
  - port-id encodings PORT_I = 1'b0, PORT_D = 1'b1;
  - the stats counter width.
- Natural sub-module: mem_resp_arb, a two-way round-robin arbiter.
  - Inputs: the two valids.
  - Outputs: one-hot grant and conflict flag.
  - Contains the pointer register.
- The array and the latency pipeline stay in mem_resp.

Test Plan:
- Reset then idle: assert iw_rst 2 cycles, drive no valids -> both rsp_valid = 0 and rsp_data = 0 throughout; ready = 0 while in reset.
- D write then I read: D write addr 0x005, data 0x00ABCD at cycle 10; I read addr 0x005 at cycle 11 -> ow_i_rsp_valid at cycle 13 (LAT = 2) with 0x00ABCD.
- Conflict round-robin: both ports valid for 4 cycles, with D reads of addresses 1..4 and I reads of 5..8 -> grants alternate I, D, I, D; each response arrives LAT cycles after its grant; a port losing arbitration holds its address.
- Read-capture hazard: D read of addr 3 (holding 0x111) at cycle 20; D write 0x222 to addr 3 at cycle 21 -> D response at cycle 22 = 0x111; a later read returns 0x222.
- Aliasing and reset flush: read addr (1 << DEPTH_LOG2) + 7 -> returns word 7; accept a read, then assert iw_rst the next cycle -> no response pulse appears.
- MEM_RESP_STATS_EN defined: 3 conflict cycles -> ow_conflict_cnt = 3 and ow_stall_cnt = 3; force more than 65535 conflicts -> both counters hold 16'hFFFF.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// ---------------------------------------------------------------------------
// mem_resp_pkg
// Shared definitions for the memory responder slice:
//   - default storage depth (log2) and read latency
//   - port-id encoding carried down the read pipeline
//   - grant vector bit positions used between arbiter and top
//   - statistics counter width and a saturating increment helper
// SIZE_DATA / SIZE_ADDR fall back to 32 bits when the surrounding build
// does not provide them.
// ---------------------------------------------------------------------------
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif
`ifndef SIZE_ADDR
`define SIZE_ADDR 32
`endif

package mem_resp_pkg;

  localparam int MEM_DEPTH_LOG2_DEF = 10;
  localparam int MEM_LAT_DEF        = 2;

  // Port id tagged onto every in-flight read.
  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  // Bit positions inside the one-hot grant vector.
  localparam int GNT_I = 0;
  localparam int GNT_D = 1;

  localparam int STATS_W = 16;

  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    if (v == {STATS_W{1'b1}}) begin
      return v;
    end
    return v + STATS_W'(1);
  endfunction

endpackage

// File: rtl/mem_resp_arb.sv
// ---------------------------------------------------------------------------
// mem_resp_arb
// Two-way round-robin arbiter between the I and D request ports.
// A lone requester is always granted. When both request in the same cycle
// the port that lost the previous conflict wins, and only conflict cycles
// move the pointer. After reset the pointer says "D granted last" so the
// first conflict goes to I.
//
// Ports:
//   i_clk      in   clock
//   i_rst      in   synchronous active-high reset
//   i_valid_i  in   I-port request valid
//   i_valid_d  in   D-port request valid
//   o_grant    out  one-hot grant, bit GNT_I = I, bit GNT_D = D
//   o_conflict out  both ports requesting this cycle
// ---------------------------------------------------------------------------
module mem_resp_arb
  import mem_resp_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid_i,
  input  logic       i_valid_d,
  output logic [1:0] o_grant,
  output logic       o_conflict
);

  logic r_last_d;
  logic w_conflict;

  assign w_conflict = i_valid_i & i_valid_d;
  assign o_conflict = w_conflict;

  always_comb begin
    o_grant = 2'b00;
    if (w_conflict) begin
      o_grant[GNT_I] = r_last_d;
      o_grant[GNT_D] = ~r_last_d;
    end else begin
      o_grant[GNT_I] = i_valid_i;
      o_grant[GNT_D] = i_valid_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_d <= 1'b1;
    end else if (w_conflict) begin
      r_last_d <= ~r_last_d;
    end
  end

endmodule

// File: rtl/mem_resp.sv
// ---------------------------------------------------------------------------
// mem_resp
// Memory-side responder serving the instruction-fetch (I) and data (D)
// initiators. Owns a word-addressed array, accepts at most one access per
// cycle (round-robin on conflicts) and returns read data exactly LAT cycles
// after acceptance. LAT must lie in 1..4.
//
// Optional build macro MEM_RESP_STATS_EN adds conflict / stall counters.
//
// Ports:
//   iw_clk           in   clock
//   iw_rst           in   synchronous active-high reset
//   iw_i_valid       in   I-port read request valid
//   ow_i_ready       out  I-port request accepted this cycle
//   iw_i_addr        in   I-port read address
//   ow_i_rsp_valid   out  I-port read data valid (1-cycle pulse)
//   ow_i_rsp_data    out  I-port read data (holds between responses)
//   iw_d_valid       in   D-port request valid
//   ow_d_ready       out  D-port request accepted this cycle
//   iw_d_we          in   D-port write enable (1 = write)
//   iw_d_addr        in   D-port address
//   iw_d_wdata       in   D-port write data
//   ow_d_rsp_valid   out  D-port read data valid (1-cycle pulse)
//   ow_d_rsp_data    out  D-port read data (holds between responses)
//   ow_conflict_cnt  out  [MEM_RESP_STATS_EN] saturating count of conflict cycles
//   ow_stall_cnt     out  [MEM_RESP_STATS_EN] saturating count of valid && !ready cycles
// ---------------------------------------------------------------------------
module mem_resp
  import mem_resp_pkg::*;
#(
  parameter int DATA_W     = `SIZE_DATA,
  parameter int ADDR_W     = `SIZE_ADDR,
  parameter int DEPTH_LOG2 = MEM_DEPTH_LOG2_DEF,
  parameter int LAT        = MEM_LAT_DEF
) (
  input  logic              iw_clk,
  input  logic              iw_rst,
  input  logic              iw_i_valid,
  output logic              ow_i_ready,
  input  logic [ADDR_W-1:0] iw_i_addr,
  output logic              ow_i_rsp_valid,
  output logic [DATA_W-1:0] ow_i_rsp_data,
  input  logic              iw_d_valid,
  output logic              ow_d_ready,
  input  logic              iw_d_we,
  input  logic [ADDR_W-1:0] iw_d_addr,
  input  logic [DATA_W-1:0] iw_d_wdata,
  output logic              ow_d_rsp_valid,
  output logic [DATA_W-1:0] ow_d_rsp_data
`ifdef MEM_RESP_STATS_EN
  ,
  output logic [STATS_W-1:0] ow_conflict_cnt,
  output logic [STATS_W-1:0] ow_stall_cnt
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0]     r_mem [DEPTH];

  logic [1:0]            w_grant;
  logic                  w_conflict;
  logic                  w_i_ready;
  logic                  w_d_ready;
  logic [DEPTH_LOG2-1:0] w_i_idx;
  logic [DEPTH_LOG2-1:0] w_d_idx;
  logic [DEPTH_LOG2-1:0] w_rd_idx;
  logic                  w_wr_en;
  logic                  w_addr_unused;

  logic                  w_rd_vld_p0;
  port_e                 w_rd_port_p0;
  logic [DATA_W-1:0]     w_rd_data_p0;

  // Entry k of these arrays is pipeline stage p(k+1); entry LAT-1 is the
  // stage whose contents are presented on the response outputs.
  logic                  r_vld_p1  [LAT];
  port_e                 r_port_p1 [LAT];
  logic [DATA_W-1:0]     r_data_p1 [LAT];

  logic                  w_rsp_vld;
  logic                  w_i_fire;
  logic                  w_d_fire;
  logic [DATA_W-1:0]     r_i_hold;
  logic [DATA_W-1:0]     r_d_hold;

  mem_resp_arb u_arb (
    .i_clk      (iw_clk),
    .i_rst      (iw_rst),
    .i_valid_i  (iw_i_valid),
    .i_valid_d  (iw_d_valid),
    .o_grant    (w_grant),
    .o_conflict (w_conflict)
  );

  // Ready is forced low during reset so nothing is accepted then.
  assign w_i_ready  = w_grant[GNT_I] & ~iw_rst;
  assign w_d_ready  = w_grant[GNT_D] & ~iw_rst;
  assign ow_i_ready = w_i_ready;
  assign ow_d_ready = w_d_ready;

  // Upper address bits alias onto the same words.
  assign w_i_idx       = iw_i_addr[DEPTH_LOG2-1:0];
  assign w_d_idx       = iw_d_addr[DEPTH_LOG2-1:0];
  assign w_addr_unused = ^{iw_i_addr[ADDR_W-1:DEPTH_LOG2], iw_d_addr[ADDR_W-1:DEPTH_LOG2]};

  // ---- stage p0: acceptance, array read captured this cycle ----
  assign w_wr_en      = w_d_ready & iw_d_we;
  assign w_rd_vld_p0  = w_i_ready | (w_d_ready & ~iw_d_we);
  assign w_rd_port_p0 = w_d_ready ? PORT_D : PORT_I;
  assign w_rd_idx     = w_d_ready ? w_d_idx : w_i_idx;
  assign w_rd_data_p0 = r_mem[w_rd_idx];

  always_ff @(posedge iw_clk) begin
    if (w_wr_en) begin
      r_mem[w_d_idx] <= iw_d_wdata;
    end
  end

  // ---- stages p1..pLAT: latency pipeline ----
  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      for (int k = 0; k < LAT; k++) begin
        r_vld_p1[k] <= 1'b0;
      end
    end else begin
      r_vld_p1[0] <= w_rd_vld_p0;
      for (int k = 1; k < LAT; k++) begin
        r_vld_p1[k] <= r_vld_p1[k-1];
      end
    end
  end

  always_ff @(posedge iw_clk) begin
    r_data_p1[0] <= w_rd_data_p0;
    r_port_p1[0] <= w_rd_port_p0;
    for (int k = 1; k < LAT; k++) begin
      r_data_p1[k] <= r_data_p1[k-1];
      r_port_p1[k] <= r_port_p1[k-1];
    end
  end

  // ---- output stage: steer by port tag, hold data between pulses ----
  // Gating with reset drops a response that would otherwise surface in the
  // same cycle reset is asserted (relevant when LAT = 1).
  assign w_rsp_vld = r_vld_p1[LAT-1] & ~iw_rst;
  assign w_i_fire  = w_rsp_vld & (r_port_p1[LAT-1] == PORT_I);
  assign w_d_fire  = w_rsp_vld & (r_port_p1[LAT-1] == PORT_D);

  assign ow_i_rsp_valid = w_i_fire;
  assign ow_d_rsp_valid = w_d_fire;
  assign ow_i_rsp_data  = w_i_fire ? r_data_p1[LAT-1] : r_i_hold;
  assign ow_d_rsp_data  = w_d_fire ? r_data_p1[LAT-1] : r_d_hold;

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      r_i_hold <= '0;
      r_d_hold <= '0;
    end else begin
      if (w_i_fire) begin
        r_i_hold <= r_data_p1[LAT-1];
      end
      if (w_d_fire) begin
        r_d_hold <= r_data_p1[LAT-1];
      end
    end
  end

`ifdef MEM_RESP_STATS_EN
  logic                 w_stall;
  logic [STATS_W-1:0]   r_conflict_cnt;
  logic [STATS_W-1:0]   r_stall_cnt;

  assign w_stall = (iw_i_valid & ~w_i_ready) | (iw_d_valid & ~w_d_ready);

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      r_conflict_cnt <= '0;
      r_stall_cnt    <= '0;
    end else begin
      if (w_conflict) begin
        r_conflict_cnt <= sat_inc(r_conflict_cnt);
      end
      if (w_stall) begin
        r_stall_cnt <= sat_inc(r_stall_cnt);
      end
    end
  end

  assign ow_conflict_cnt = r_conflict_cnt;
  assign ow_stall_cnt    = r_stall_cnt;
`else
  logic w_stats_unused;
  assign w_stats_unused = w_conflict;
`endif

endmodule

// File: tb/tb_mem_resp.sv
// ---------------------------------------------------------------------------
// tb_mem_resp
// Scoreboard bench for mem_resp: the stimulus side pushes hand-computed
// expected read data (with due cycle) into per-port queues; a monitor pops
// and compares on every response pulse.
// ---------------------------------------------------------------------------
module tb_mem_resp;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int DL  = 10;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic          i_ready;
  logic [AW-1:0] i_addr = '0;
  logic          i_rsp_valid;
  logic [DW-1:0] i_rsp_data;
  logic          d_valid = 1'b0;
  logic          d_ready;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_rsp_valid;
  logic [DW-1:0] d_rsp_data;
`ifdef MEM_RESP_STATS_EN
  logic [15:0]   conflict_cnt;
  logic [15:0]   stall_cnt;
`endif

  mem_resp #(
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .DEPTH_LOG2 (DL),
    .LAT        (LAT)
  ) dut (
    .iw_clk         (clk),
    .iw_rst         (rst),
    .iw_i_valid     (i_valid),
    .ow_i_ready     (i_ready),
    .iw_i_addr      (i_addr),
    .ow_i_rsp_valid (i_rsp_valid),
    .ow_i_rsp_data  (i_rsp_data),
    .iw_d_valid     (d_valid),
    .ow_d_ready     (d_ready),
    .iw_d_we        (d_we),
    .iw_d_addr      (d_addr),
    .iw_d_wdata     (d_wdata),
    .ow_d_rsp_valid (d_rsp_valid),
    .ow_d_rsp_data  (d_rsp_data)
`ifdef MEM_RESP_STATS_EN
    ,
    .ow_conflict_cnt (conflict_cnt),
    .ow_stall_cnt    (stall_cnt)
`endif
  );

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } exp_t;

  exp_t q_i[$];
  exp_t q_d[$];
  exp_t em_i;
  exp_t em_d;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   mon_en = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] ev);
    total++;
    if (act !== ev) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, ev);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: event occurred that should not", name);
  endtask

  // Monitor: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (i_rsp_valid) begin
        if (q_i.size() == 0) begin
          fail_now("i_rsp_unexpected");
        end else begin
          em_i = q_i.pop_front();
          chk("i_rsp_data", 64'(i_rsp_data), 64'(em_i.data));
          chk("i_rsp_cycle", 64'(cyc), 64'(em_i.due));
        end
      end
      if (d_rsp_valid) begin
        if (q_d.size() == 0) begin
          fail_now("d_rsp_unexpected");
        end else begin
          em_d = q_d.pop_front();
          chk("d_rsp_data", 64'(d_rsp_data), 64'(em_d.data));
          chk("d_rsp_cycle", 64'(cyc), 64'(em_d.due));
        end
      end
    end
  end

  // Single request on one port, held until accepted (bounded wait).
  task automatic req(input bit pd, input bit we, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wd, input logic [DW-1:0] ev, input bit push);
    int n;
    n = 0;
    if (pd) begin
      d_valid = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
    end else begin
      i_valid = 1'b1; i_addr = addr;
    end
    @(negedge clk);
    while (!(pd ? d_ready : i_ready) && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (n >= 20) begin
      fail_now("req_timeout");
    end else if (push && !we) begin
      if (pd) q_d.push_back('{cyc + LAT, ev});
      else    q_i.push_back('{cyc + LAT, ev});
    end
    @(posedge clk); #1;
    if (pd) d_valid = 1'b0;
    else    i_valid = 1'b0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ia;
    int da;
    bit gi;
    bit gd;

    // Reset held two cycles, no requests.
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_i_ready", 64'(i_ready), 64'(0));
      chk("rst_d_ready", 64'(d_ready), 64'(0));
      chk("rst_i_rsp_valid", 64'(i_rsp_valid), 64'(0));
      chk("rst_d_rsp_valid", 64'(d_rsp_valid), 64'(0));
      chk("rst_i_rsp_data", 64'(i_rsp_data), 64'(0));
      chk("rst_d_rsp_data", 64'(d_rsp_data), 64'(0));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // D write then I read of the same word on the next cycle.
    req(1'b1, 1'b1, 32'h005, 32'h00ABCD, 32'h0, 1'b0);
    req(1'b0, 1'b0, 32'h005, 32'h0, 32'h00ABCD, 1'b1);

    // Preload words 1..8 with 0x1000+k.
    for (int k = 1; k <= 8; k++) begin
      req(1'b1, 1'b1, AW'(k), DW'(32'h1000 + k), 32'h0, 1'b0);
    end

    // Both ports requesting: I 5..8, D 1..4, strict alternation I,D,I,D...
    ia = 5;
    da = 1;
    for (int s = 0; s < 8; s++) begin
      i_valid = (ia <= 8);
      i_addr  = AW'(ia);
      d_valid = (da <= 4);
      d_we    = 1'b0;
      d_addr  = AW'(da);
      @(negedge clk);
      chk("conf_i_ready", 64'(i_ready), 64'(s % 2 == 0));
      chk("conf_d_ready", 64'(d_ready), 64'(s % 2 == 1));
      gi = i_ready;
      gd = d_ready;
      if (gi) q_i.push_back('{cyc + LAT, DW'(32'h1000 + ia)});
      if (gd) q_d.push_back('{cyc + LAT, DW'(32'h1000 + da)});
      @(posedge clk); #1;
      if (gi) ia++;
      if (gd) da++;
    end
    i_valid = 1'b0;
    d_valid = 1'b0;

    // Read captured at acceptance is not disturbed by a following write.
    req(1'b1, 1'b1, 32'h003, 32'h111, 32'h0, 1'b0);
    req(1'b1, 1'b0, 32'h003, 32'h0, 32'h111, 1'b1);
    req(1'b1, 1'b1, 32'h003, 32'h222, 32'h0, 1'b0);
    req(1'b1, 1'b0, 32'h003, 32'h0, 32'h222, 1'b1);

    // Aliasing: upper address bits ignored.
    req(1'b0, 1'b0, AW'((1 << DL) + 7), 32'h0, 32'h1007, 1'b1);
    repeat (LAT + 2) @(posedge clk);
    #1;
    chk("i_rsp_data_hold", 64'(i_rsp_data), 64'h1007);
    chk("d_rsp_data_hold", 64'(d_rsp_data), 64'h222);

    // Accept a read, then reset next cycle: its response must vanish.
    req(1'b0, 1'b0, 32'h002, 32'h0, 32'h0, 1'b0);
    rst = 1'b1;
    i_valid = 1'b1; i_addr = 32'h002;
    d_valid = 1'b1; d_we = 1'b0; d_addr = 32'h002;
    @(negedge clk);
    chk("midrst_i_ready", 64'(i_ready), 64'(0));
    chk("midrst_d_ready", 64'(d_ready), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    i_valid = 1'b0;
    d_valid = 1'b0;
    @(negedge clk);
    chk("flush_i_rsp_data", 64'(i_rsp_data), 64'(0));
    chk("flush_d_rsp_data", 64'(d_rsp_data), 64'(0));
    repeat (4) @(posedge clk);
    #1;

    // Three conflicts after reset: pointer restarted, so I,D,I.
    for (int s = 0; s < 3; s++) begin
      i_valid = 1'b1; i_addr = 32'h001;
      d_valid = 1'b1; d_we = 1'b1; d_addr = 32'h009; d_wdata = DW'(s);
      @(negedge clk);
      chk("rr_i_ready", 64'(i_ready), 64'(s % 2 == 0));
      chk("rr_d_ready", 64'(d_ready), 64'(s % 2 == 1));
      if (i_ready) q_i.push_back('{cyc + LAT, 32'h1001});
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    d_valid = 1'b0;
    d_we    = 1'b0;
`ifdef MEM_RESP_STATS_EN
    @(negedge clk);
    chk("conflict_cnt_3", 64'(conflict_cnt), 64'd3);
    chk("stall_cnt_3", 64'(stall_cnt), 64'd3);
    repeat (LAT + 2) @(posedge clk);
    #1;
    mon_en = 1'b0;
    i_valid = 1'b1; i_addr = 32'h001;
    d_valid = 1'b1; d_we = 1'b1; d_addr = 32'h009;
    repeat (65540) @(posedge clk);
    @(negedge clk);
    chk("conflict_cnt_sat", 64'(conflict_cnt), 64'hFFFF);
    chk("stall_cnt_sat", 64'(stall_cnt), 64'hFFFF);
    @(posedge clk); #1;
    i_valid = 1'b0;
    d_valid = 1'b0;
    d_we    = 1'b0;
    repeat (LAT + 3) @(posedge clk);
    #1;
    mon_en = 1'b1;
`endif

    repeat (LAT + 3) @(posedge clk);
    @(negedge clk);
    chk("i_queue_drained", 64'(q_i.size()), 64'(0));
    chk("d_queue_drained", 64'(q_d.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
